pipeline_ctrl: RTL

// - Central stall/flush/drain controller for the N-stage in-order pipeline (IF,ID,EX,MEM,WB at default).
// - Generates per-pipe-register write enables and bubble (flush) controls, the PC enable and the halt

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/sat_counter.sv | 33 +++
 rtl/pipeline_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared types for the in-order pipeline control path.
//                - pc_state_t : run / drain / halted state of the controller
//                - STG_*      : stage indices (pipe reg i feeds stage i, so the
//                               valid bit of stage s lives at index s-1)
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

   typedef enum logic [1:0] {
      PC_RUN    = 2'd0,
      PC_DRAIN  = 2'd1,
      PC_HALTED = 2'd2
   } pc_state_t;

   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Event counter that sticks at its all-ones maximum.
//  Ports       : CLK   in  clock, rising edge
//                RST   in  asynchronous active-high reset (clears count)
//                inc   in  count one event this cycle
//                value out current count
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
   parameter int CNTW = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            inc,
   output logic [CNTW-1:0] value
);

   logic [CNTW-1:0] r_value;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_value <= '0;
      end else if (inc && (r_value != {CNTW{1'b1}})) begin
         r_value <= r_value + 1'b1;
      end
   end

   assign value = r_value;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Stall / flush / drain controller for an N-stage in-order
//                pipeline. Produces per-pipe-register load enables and bubble
//                controls, the PC enable and the halt indication; tracks the
//                per-register valid bits; counts stall and redirect cycles.
//  Ports       : CLK, RST                 clock / async active-high reset
//                ihit                     fetch returned this cycle
//                dmem_req, dhit           MEM-stage data access / completion
//                id_rs, id_rt, id_uses_rt ID-stage source operands
//                ex_memread, ex_wsel      EX-stage load and destination
//                ex_redirect              taken branch/jump resolved
//                id_halt                  HALT sitting in ID
//                pc_en                    PC update enable
//                preg_en[i-1]             pipe reg i loads
//                preg_flush[i-1]          pipe reg i loads a bubble
//                stage_valid[i-1]         pipe reg i holds a real instruction
//                halt                     sticky, pipeline drained after HALT
//                stall_cnt, flush_cnt     saturating performance counters
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_ctrl
   import cpu_types_pkg::*;
#(
   parameter int NSTAGES        = 5,
   parameter int REDIRECT_STAGE = 2,
   parameter int REGW           = 5,
   parameter int CNTW           = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               ihit,
   input  logic               dmem_req,
   input  logic               dhit,
   input  logic [REGW-1:0]    id_rs,
   input  logic [REGW-1:0]    id_rt,
   input  logic               id_uses_rt,
   input  logic               ex_memread,
   input  logic [REGW-1:0]    ex_wsel,
   input  logic               ex_redirect,
   input  logic               id_halt,
   output logic               pc_en,
   output logic [NSTAGES-2:0] preg_en,
   output logic [NSTAGES-2:0] preg_flush,
   output logic [NSTAGES-2:0] stage_valid,
   output logic               halt,
   output logic [CNTW-1:0]    stall_cnt,
   output logic [CNTW-1:0]    flush_cnt
);

   localparam int NP  = NSTAGES - 1;
   localparam int DCW = $clog2(NSTAGES - 1);
   // Redirect squashes every pipe reg up to and including the one feeding
   // the resolving stage.
   localparam logic [NP-1:0] c_REDIR_MASK =
      {{(NP - REDIRECT_STAGE){1'b0}}, {REDIRECT_STAGE{1'b1}}};
   localparam logic [DCW-1:0] c_DRAIN_LOAD = DCW'(NSTAGES - 2);

   pc_state_t         r_state;
   logic [DCW-1:0]    r_drain_cnt;
   logic [NP-1:0]     r_valid;

   logic              w_v_id;
   logic              w_v_ex;
   logic              w_v_mem;
   logic              w_v_redir;
   logic              w_running;
   logic              w_draining;
   logic              w_memstall;
   logic              w_redirect;
   logic              w_hazard_match;
   logic              w_loaduse;
   logic              w_imiss;
   logic              w_pc_en;
   logic [NP-1:0]     w_en;
   logic [NP-1:0]     w_fl;
   logic [NP-1:0]     w_valid_src;
   logic              w_stall_inc;
   logic              w_flush_inc;
   logic              w_advance;

   assign w_v_id     = r_valid[STG_ID - 1];
   assign w_v_ex     = r_valid[STG_EX - 1];
   assign w_v_mem    = r_valid[STG_MEM - 1];
   assign w_v_redir  = r_valid[REDIRECT_STAGE - 1];
   assign w_running  = (r_state == PC_RUN);
   assign w_draining = (r_state == PC_DRAIN);

   // Fetch misses and redirects only matter while running: during drain the
   // front end is already shut off and nothing younger than HALT is live.
   assign w_memstall     = dmem_req & ~dhit & w_v_mem;
   assign w_redirect     = ex_redirect & w_v_redir & w_running;
   assign w_hazard_match = (ex_wsel != '0) &&
                           ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));
   assign w_loaduse      = ex_memread & w_v_ex & w_v_id & w_hazard_match;
   assign w_imiss        = ~ihit & w_running;

   // Priority mux: first matching condition decides the whole cycle.
   always_comb begin
      w_pc_en     = 1'b0;
      w_en        = '0;
      w_fl        = '0;
      w_stall_inc = 1'b0;
      w_flush_inc = 1'b0;
      w_advance   = 1'b0;
      if (!RST && (r_state != PC_HALTED)) begin
         if (w_memstall) begin
            w_stall_inc = 1'b1;
         end else if (w_redirect) begin
            w_pc_en     = 1'b1;
            w_en        = '1;
            w_fl        = c_REDIR_MASK;
            w_flush_inc = 1'b1;
         end else if (w_loaduse) begin
            // Hold IF/ID, drop a bubble into EX, let older work retire.
            w_en                 = '1;
            w_en[STG_ID - 1]     = 1'b0;
            w_fl[STG_EX - 1]     = 1'b1;
            w_stall_inc          = 1'b1;
         end else if (w_imiss) begin
            w_en                 = '1;
            w_fl[STG_ID - 1]     = 1'b1;
            w_stall_inc          = 1'b1;
            w_advance            = 1'b1;
         end else begin
            w_pc_en              = ~w_draining;
            w_en                 = '1;
            w_fl[STG_ID - 1]     = w_draining;
            w_advance            = 1'b1;
         end
      end
   end

   // Source of each pipe reg's valid bit: the previous reg, or a fresh
   // fetch for IF/ID.
   assign w_valid_src = {r_valid[NP-2:0], 1'b1};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_valid <= '0;
      end else begin
         r_valid <= (w_en & ~w_fl & w_valid_src) | (~w_en & r_valid);
      end
   end

   // r_drain_cnt holds the number of advancing cycles still needed for the
   // HALT to leave the last pipe reg; the final one moves to HALTED.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= PC_RUN;
         r_drain_cnt <= '0;
      end else begin
         case (r_state)
            PC_RUN: begin
               if (id_halt && w_v_id && w_advance) begin
                  r_state     <= PC_DRAIN;
                  r_drain_cnt <= c_DRAIN_LOAD;
               end
            end
            PC_DRAIN: begin
               if (w_advance) begin
                  if (r_drain_cnt <= DCW'(1)) begin
                     r_state     <= PC_HALTED;
                     r_drain_cnt <= '0;
                  end else begin
                     r_drain_cnt <= r_drain_cnt - DCW'(1);
                  end
               end
            end
            PC_HALTED: begin
               r_state <= PC_HALTED;
            end
            default: begin
               r_state     <= PC_RUN;
               r_drain_cnt <= '0;
            end
         endcase
      end
   end

   sat_counter #(.CNTW(CNTW)) u_stall_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (w_stall_inc),
      .value (stall_cnt)
   );

   sat_counter #(.CNTW(CNTW)) u_flush_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (w_flush_inc),
      .value (flush_cnt)
   );

   assign pc_en       = w_pc_en;
   assign preg_en     = w_en;
   assign preg_flush  = w_fl;
   assign stage_valid = r_valid;
   assign halt        = (r_state == PC_HALTED);

endmodule : pipeline_ctrl
`default_nettype wire
